mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller at the consuming end of the EX/MEM pipeline register.
- Takes the registered MemRead/MemWrite/address/store-data/CreateDump/Err signals and runs a request/acknowledge transaction with a multi-cycle data memory.
- Drives Stall_disable back to the pipeline registers, holding them until the access completes.
- Presents load data, a halt indication and an error to the MEM/WB stage.

Parameters:
TIMEOUT, 15, maximum BUSY cycles waited for mem_ack before declaring an error (1..2^CNT_W-1)
CNT_W, 4, width of the wait-cycle counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
MemRead_in  in  1  load in MEM stage (from EX/MEM)
MemWrite_in  in  1  store in MEM stage (from EX/MEM)
CreateDump_in  in  1  HALT instruction in MEM stage
Err_in  in  1  error piped from earlier stages
Addr_in  in  16  execute result used as byte address
WriteData_in  in  16  store data (RegData2 from EX/MEM)
mem_req  out  1  memory request, level, held until ack
mem_wr  out  1  1 = write, 0 = read, valid while mem_req
mem_addr  out  16  latched address
mem_wdata  out  16  latched store data
mem_ack  in  1  one-cycle completion pulse from memory
mem_rdata  in  16  read data, valid with mem_ack
Stall_disable  out  1  1 = hold all upstream pipeline registers
ReadData_out  out  16  last completed load data
Halt_out  out  1  sticky, processor halted
err  out  1  sticky error

Behaviour:
- States: IDLE, BUSY, DONE, HALTED, ERROR.
- Encoding is free; one-hot or binary is acceptable.
- Reset (rst=0, asynchronous) forces:
  - state IDLE, counter 0
  - mem_req/mem_wr 0; mem_addr, mem_wdata and ReadData_out 0x0000
  - Stall_disable, Halt_out and err all 0
- Reset asserted mid-BUSY drops mem_req immediately, without waiting for a clock edge. No ack is expected afterwards.
- IDLE:
  - Access = MemRead_in|MemWrite_in.
  - Error checks, evaluated in this priority order, each sending the FSM to ERROR on the next edge:
    1. Err_in=1
    2. MemRead_in&MemWrite_in
    3. access with Addr_in[0]=1 (misaligned)
    In all three cases no request is issued.
  - Otherwise, on an access:
    - Stall_disable=1 combinationally in the same cycle.
    - At the edge, latch Addr_in, WriteData_in and MemWrite_in into mem_addr/mem_wdata/mem_wr; clear the counter; go to BUSY.
  - Otherwise, if CreateDump_in: go to HALTED.
  - Otherwise: stay in IDLE with Stall_disable=0.
- BUSY:
  - mem_req=1 and Stall_disable=1.
  - On mem_ack:
    - If the access is a read, ReadData_out <= mem_rdata at that edge.
    - Go to DONE.
  - Without ack: counter increments. If the counter equals TIMEOUT and mem_ack=0 → ERROR.
  - An ack in the same cycle the counter reaches TIMEOUT counts as success.
- DONE:
  - mem_req=0, Stall_disable=0 for exactly one cycle, so EX/MEM advances.
  - Return to IDLE unconditionally.
  - The held instruction is never relaunched, because DONE ignores the MemRead_in/MemWrite_in inputs.
- Timing:
  - Minimum access is 3 cycles: IDLE detect, BUSY with ack, DONE.
  - Stall_disable is high for the first 2 of those cycles.
- ReadData_out holds its value until the next completed read; writes do not change it.
- HALTED:
  - Halt_out=1, Stall_disable=0, mem_req=0.
  - All inputs are ignored until reset.
- ERROR:
  - err=1, Stall_disable=0, mem_req=0.
  - Sticky until reset; Halt_out unchanged.
- A mem_ack arriving in IDLE, DONE, HALTED or ERROR is ignored and has no state effect.
- Simultaneous access and CreateDump_in in IDLE: the access takes priority. The halt is taken on a later IDLE cycle while CreateDump_in persists.
- mem_addr, mem_wdata and mem_wr are stable for the whole of BUSY, independent of input changes.

Test Plan:
- Read, ack after 1 cycle:
  - Stimulus: MemRead_in=1, Addr_in=0x0010, mem_rdata=0xBEEF.
  - Required: Stall_disable=1 for 2 cycles; mem_req=1, mem_wr=0, mem_addr=0x0010 during BUSY; ReadData_out=0xBEEF from the DONE cycle; Stall_disable=0 in DONE.
- Write, ack after 4 BUSY cycles:
  - Stimulus: MemWrite_in=1, Addr_in=0x0122, WriteData_in=0x1234.
  - Inputs change to 0xFFFF during BUSY.
  - Required: mem_wdata stays 0x1234; mem_addr stays 0x0122; Stall_disable=1 for 5 cycles; ReadData_out unchanged.
- Timeout:
  - Stimulus: read with mem_ack never asserted, TIMEOUT=15.
  - Required: ERROR entered after 15 BUSY cycles; err=1, mem_req=0, Stall_disable=0; state held until rst=0.
- Misaligned and illegal:
  - Stimulus: Addr_in=0x0003 with MemRead_in=1 → err=1 next cycle, mem_req never 1.
  - Stimulus (after reset): MemRead_in=MemWrite_in=1 → err=1.
- Halt:
  - Stimulus: CreateDump_in=1 with no access.
  - Required: Halt_out=1 next cycle; a later MemRead_in=1 produces no mem_req.
  - Stimulus (separately): CreateDump_in with MemRead_in=1 → read completes first, then Halt_out=1.
- Async reset mid-access:
  - Stimulus: rst=0 asserted mid-cycle during BUSY.
  - Required: mem_req and Stall_disable fall before the next clock edge; all outputs return to reset values; a late mem_ack after release is ignored.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs a req/ack transaction with a multi-cycle data memory
// while stalling the upstream pipeline, and reports load data, halt and error to MEM/WB.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        CreateDump_in,
  input  logic        Err_in,
  input  logic [15:0] Addr_in,
  input  logic [15:0] WriteData_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        Stall_disable,
  output logic [15:0] ReadData_out,
  output logic        Halt_out,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY   = 3'd1,
    S_DONE   = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             wr_q, wr_d;
  logic             access;
  logic             illegal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    access  = MemRead_in | MemWrite_in;
    // Upstream error, read+write together, or odd byte address on an access.
    illegal = Err_in | (MemRead_in & MemWrite_in) | (access & Addr_in[0]);

    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    wr_d          = wr_q;
    Stall_disable = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (illegal) begin
          state_d = S_ERROR;
        end else if (access) begin
          Stall_disable = 1'b1;
          addr_d        = Addr_in;
          wdata_d       = WriteData_in;
          wr_d          = MemWrite_in;
          cnt_d         = '0;
          state_d       = S_BUSY;
        end else if (CreateDump_in) begin
          state_d = S_HALTED;
        end
      end
      S_BUSY: begin
        Stall_disable = 1'b1;
        if (mem_ack) begin
          if (!wr_q) rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          // An ack arriving in the final allowed cycle still wins over the timeout.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(TIMEOUT)) state_d = S_ERROR;
        end
      end
      S_DONE:   state_d = S_IDLE;
      S_HALTED: state_d = S_HALTED;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_req      = (state_q == S_BUSY);
  assign mem_wr       = wr_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign ReadData_out = rdata_q;
  assign Halt_out     = (state_q == S_HALTED);
  assign err          = (state_q == S_ERROR);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl: inputs driven 1ns after the rising edge,
// outputs checked at the falling edge.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in, CreateDump_in, Err_in;
  logic [15:0] Addr_in, WriteData_in;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        Stall_disable;
  logic [15:0] ReadData_out;
  logic        Halt_out, err;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .CreateDump_in(CreateDump_in), .Err_in(Err_in),
    .Addr_in(Addr_in), .WriteData_in(WriteData_in),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .Stall_disable(Stall_disable), .ReadData_out(ReadData_out),
    .Halt_out(Halt_out), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic clear_inputs();
    MemRead_in = 0; MemWrite_in = 0; CreateDump_in = 0; Err_in = 0;
    Addr_in = 16'h0000; WriteData_in = 16'h0000; mem_ack = 0; mem_rdata = 16'h0000;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick(); tick();
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    tick(); mid();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_req); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", mem_wr); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h want 0000", mem_wdata); end
    checks++; if (ReadData_out !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", ReadData_out); end
    checks++; if ({Stall_disable, Halt_out, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {Stall_disable, Halt_out, err}); end
    tick();
    rst = 1;
    // Idle with no access: no stall.
    tick(); mid();
    checks++; if (Stall_disable !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", Stall_disable); end
  endtask

  task automatic test_read();
    tick();
    MemRead_in = 1; Addr_in = 16'h0010; mem_rdata = 16'hBEEF;
    mid();
    checks++; if ({Stall_disable, mem_req} !== 2'b10) begin errors++; $display("FAIL rd_idle: stall/req got %b want 10", {Stall_disable, mem_req}); end
    tick();
    MemRead_in = 0; Addr_in = 16'h0000; mem_ack = 1;
    mid();
    checks++; if ({Stall_disable, mem_req, mem_wr} !== 3'b110) begin errors++; $display("FAIL rd_busy: stall/req/wr got %b want 110", {Stall_disable, mem_req, mem_wr}); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_addr: got %h want 0010", mem_addr); end
    tick();
    mem_ack = 0;
    mid();
    checks++; if ({Stall_disable, mem_req} !== 2'b00) begin errors++; $display("FAIL rd_done: stall/req got %b want 00", {Stall_disable, mem_req}); end
    checks++; if (ReadData_out !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want BEEF", ReadData_out); end
    tick(); mid();
    checks++; if ({Stall_disable, mem_req, err} !== 3'b000) begin errors++; $display("FAIL rd_back_idle: got %b want 000", {Stall_disable, mem_req, err}); end
  endtask

  task automatic test_write();
    int stalls;
    stalls = 0;
    tick();
    MemWrite_in = 1; Addr_in = 16'h0122; WriteData_in = 16'h1234; mem_rdata = 16'h7777;
    mid();
    if (Stall_disable === 1'b1) stalls++;
    for (int i = 0; i < 4; i++) begin
      tick();
      MemWrite_in = 0; Addr_in = 16'hFFFF; WriteData_in = 16'hFFFF;
      mem_ack = (i == 3);
      mid();
      if (Stall_disable === 1'b1) stalls++;
      checks++; if ({mem_req, mem_wr} !== 2'b11) begin errors++; $display("FAIL wr_busy%0d: req/wr got %b want 11", i, {mem_req, mem_wr}); end
      checks++; if (mem_wdata !== 16'h1234 || mem_addr !== 16'h0122) begin errors++; $display("FAIL wr_hold%0d: addr %h data %h want 0122 1234", i, mem_addr, mem_wdata); end
    end
    tick();
    mem_ack = 0; Addr_in = 16'h0000; WriteData_in = 16'h0000;
    mid();
    if (Stall_disable === 1'b1) stalls++;
    checks++; if (stalls != 5) begin errors++; $display("FAIL wr_stall_cycles: got %0d want 5", stalls); end
    checks++; if (ReadData_out !== 16'hBEEF) begin errors++; $display("FAIL wr_rdata_kept: got %h want BEEF", ReadData_out); end
    tick();
  endtask

  task automatic test_ack_at_limit();
    tick();
    MemRead_in = 1; Addr_in = 16'h0030; mem_rdata = 16'hC0DE;
    for (int i = 0; i < 15; i++) begin
      tick();
      MemRead_in = 0;
      mem_ack = (i == 14);
    end
    tick();
    mem_ack = 0;
    mid();
    checks++; if ({err, Stall_disable, mem_req} !== 3'b000) begin errors++; $display("FAIL ack_limit_done: err/stall/req got %b want 000", {err, Stall_disable, mem_req}); end
    checks++; if (ReadData_out !== 16'hC0DE) begin errors++; $display("FAIL ack_limit_data: got %h want C0DE", ReadData_out); end
    tick();
    mem_ack = 1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 0;
    mid();
    checks++; if ({mem_req, err, ReadData_out} !== {2'b00, 16'hC0DE}) begin errors++; $display("FAIL idle_ack_ignored: req/err/data got %b %b %h want 0 0 C0DE", mem_req, err, ReadData_out); end
  endtask

  task automatic test_timeout();
    int busy;
    busy = 0;
    do_reset();
    tick();
    MemRead_in = 1; Addr_in = 16'h0020;
    for (int i = 0; i < 15; i++) begin
      tick();
      MemRead_in = 0;
      mid();
      if (mem_req === 1'b1) busy++;
    end
    checks++; if (busy != 15) begin errors++; $display("FAIL to_busy_cycles: got %0d want 15", busy); end
    tick(); mid();
    checks++; if ({err, mem_req, Stall_disable} !== 3'b100) begin errors++; $display("FAIL to_error: err/req/stall got %b want 100", {err, mem_req, Stall_disable}); end
    MemRead_in = 1; Addr_in = 16'h0040; mem_ack = 1;
    tick(); tick(); mid();
    checks++; if ({err, mem_req, Stall_disable, Halt_out} !== 4'b1000) begin errors++; $display("FAIL to_sticky: got %b want 1000", {err, mem_req, Stall_disable, Halt_out}); end
    do_reset();
    tick(); mid();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_cleared: err got %b want 0", err); end
  endtask

  task automatic test_illegal();
    int reqs;
    reqs = 0;
    do_reset();
    tick();
    MemRead_in = 1; Addr_in = 16'h0003;
    mid();
    if (mem_req === 1'b1) reqs++;
    checks++; if (Stall_disable !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b want 0", Stall_disable); end
    tick(); mid();
    if (mem_req === 1'b1) reqs++;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b want 1", err); end
    checks++; if (reqs != 0) begin errors++; $display("FAIL mis_req: req seen %0d times want 0", reqs); end
    do_reset();
    tick();
    MemRead_in = 1; MemWrite_in = 1; Addr_in = 16'h0010;
    tick(); mid();
    checks++; if ({err, mem_req} !== 2'b10) begin errors++; $display("FAIL rdwr_err: err/req got %b want 10", {err, mem_req}); end
    do_reset();
    tick();
    Err_in = 1; MemRead_in = 1; Addr_in = 16'h0010;
    tick(); mid();
    checks++; if ({err, mem_req} !== 2'b10) begin errors++; $display("FAIL errin_err: err/req got %b want 10", {err, mem_req}); end
  endtask

  task automatic test_halt();
    int reqs;
    reqs = 0;
    do_reset();
    tick();
    CreateDump_in = 1;
    tick();
    CreateDump_in = 0;
    mid();
    checks++; if (Halt_out !== 1'b1) begin errors++; $display("FAIL halt_set: got %b want 1", Halt_out); end
    MemRead_in = 1; Addr_in = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      tick(); mid();
      if (mem_req === 1'b1 || Stall_disable === 1'b1) reqs++;
    end
    checks++; if (reqs != 0 || Halt_out !== 1'b1) begin errors++; $display("FAIL halt_ignores: req/stall seen %0d halt %b want 0 1", reqs, Halt_out); end
    do_reset();
    tick();
    CreateDump_in = 1; MemRead_in = 1; Addr_in = 16'h0040; mem_rdata = 16'h5A5A;
    mid();
    checks++; if ({Stall_disable, Halt_out} !== 2'b10) begin errors++; $display("FAIL halt_acc_first: stall/halt got %b want 10", {Stall_disable, Halt_out}); end
    tick();
    MemRead_in = 0; mem_ack = 1;
    mid();
    checks++; if ({mem_req, Halt_out} !== 2'b10) begin errors++; $display("FAIL halt_acc_busy: req/halt got %b want 10", {mem_req, Halt_out}); end
    tick();
    mem_ack = 0;
    mid();
    checks++; if ({Halt_out, ReadData_out} !== {1'b0, 16'h5A5A}) begin errors++; $display("FAIL halt_acc_done: halt %b data %h want 0 5A5A", Halt_out, ReadData_out); end
    tick(); tick(); mid();
    checks++; if (Halt_out !== 1'b1) begin errors++; $display("FAIL halt_after_acc: got %b want 1", Halt_out); end
    CreateDump_in = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    MemRead_in = 1; Addr_in = 16'h0088; mem_rdata = 16'hABCD;
    tick();
    MemRead_in = 0;
    mid();
    checks++; if ({mem_req, Stall_disable} !== 2'b11) begin errors++; $display("FAIL ar_busy: req/stall got %b want 11", {mem_req, Stall_disable}); end
    rst = 0;
    #1;
    checks++; if ({mem_req, Stall_disable} !== 2'b00) begin errors++; $display("FAIL ar_immediate: req/stall got %b want 00", {mem_req, Stall_disable}); end
    checks++; if ({mem_wr, mem_addr, mem_wdata, ReadData_out, Halt_out, err} !== 51'd0) begin errors++; $display("FAIL ar_values: addr %h wdata %h data %h", mem_addr, mem_wdata, ReadData_out); end
    tick();
    rst = 1;
    tick();
    mem_ack = 1;
    tick();
    mem_ack = 0;
    mid();
    checks++; if ({mem_req, Stall_disable, err, ReadData_out} !== {3'b000, 16'h0000}) begin errors++; $display("FAIL ar_late_ack: req/stall/err %b data %h want 000 0000", {mem_req, Stall_disable, err}, ReadData_out); end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_read();
    test_write();
    test_ack_at_limit();
    test_timeout();
    test_illegal();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
